// File: rtl/opsum_wb_packer.sv
// Drains 16-bit partial sums from opsum_fifo, packs them in pairs into 32-bit
// words and writes them to the GLB opsum region through a ready-gated port.
module opsum_wb_packer #(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  num_elem,
   output logic              busy,
   output logic              done,
   output logic              fifo_pop_en,
   output logic              fifo_pop_mod,
   input  logic [31:0]       fifo_pop_data,
   input  logic              fifo_empty,
   output logic [3:0]        glb_we,
   output logic [ADDR_W-1:0] glb_addr,
   output logic [31:0]       glb_wdata,
   input  logic              glb_ready
);

   typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] wr_addr;
   logic [LEN_W-1:0]  remaining;
   logic [1:0]        pop_cnt;
   logic [1:0]        cap_cnt;
   logic [31:0]       word;
   logic              cap_pending;

   logic [1:0]        cap_next;
   logic [31:0]       word_next;
   logic              cap_last;
   logic [LEN_W-1:0]  rem_after;

   assign fifo_pop_mod = 1'b0;

   // Pop decision uses the live empty flag so a pop is never issued to an empty FIFO.
   assign fifo_pop_en = (state == FETCH) && !fifo_empty && (pop_cnt < 2'd2) &&
                        ({{(LEN_W-2){1'b0}}, pop_cnt} < remaining);

   always_comb begin
      cap_next  = cap_cnt + 2'd1;
      word_next = word;
      if (cap_cnt == 2'd0)
         word_next[15:0] = fifo_pop_data[15:0];
      else
         word_next[31:16] = fifo_pop_data[15:0];
      cap_last  = (cap_next == 2'd2) || ({{(LEN_W-2){1'b0}}, cap_next} == remaining);
      rem_after = remaining - {{(LEN_W-2){1'b0}}, cap_cnt};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         wr_addr     <= '0;
         remaining   <= '0;
         pop_cnt     <= '0;
         cap_cnt     <= '0;
         word        <= '0;
         cap_pending <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         glb_we      <= '0;
         glb_addr    <= '0;
         glb_wdata   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  wr_addr     <= base_addr;
                  remaining   <= num_elem;
                  pop_cnt     <= '0;
                  cap_cnt     <= '0;
                  word        <= '0;
                  cap_pending <= 1'b0;
                  if (num_elem == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= FETCH;
                     busy  <= 1'b1;
                  end
               end
            end
            FETCH: begin
               cap_pending <= fifo_pop_en;
               if (fifo_pop_en)
                  pop_cnt <= pop_cnt + 2'd1;
               // Data arrives one cycle after its pop; the final capture launches the write.
               if (cap_pending) begin
                  word    <= word_next;
                  cap_cnt <= cap_next;
                  if (cap_last) begin
                     state     <= WRITE;
                     glb_addr  <= wr_addr;
                     glb_wdata <= word_next;
                     glb_we    <= (cap_next == 2'd2) ? 4'b1111 : 4'b0011;
                  end
               end
            end
            WRITE: begin
               if (glb_ready) begin
                  glb_we      <= '0;
                  wr_addr     <= wr_addr + ADDR_W'(4);
                  remaining   <= rem_after;
                  pop_cnt     <= '0;
                  cap_cnt     <= '0;
                  word        <= '0;
                  cap_pending <= 1'b0;
                  if (rem_after == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state <= FETCH;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
